univ_shift_reg: RTL

Parametrised universal shift register, the next generation of the team's single-direction shift register. It adds run-time mode selection (logical/arithmetic shift, rotate, both directions), multi-bit shift steps and a counted burst-shift engine with busy/done handshake. It sits between parallel datapath registers and serial links or bit-serial arithmetic, where a controller issues "shift N times" commands.

---
 rtl/univ_shift_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
// Supports run-time selectable logical/arithmetic shifts and rotates in both
// directions, STEP bits per operation, and a counted burst engine that runs
// "shift N times" commands with a busy flag and a one-cycle done pulse.
module univ_shift_reg #(
  parameter int WIDTH  = 8,
  parameter int STEP   = 1,
  parameter int CNT_W  = 4,
  parameter int SVALUE = 3
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               enable,
  input  logic               sclr,
  input  logic               sset,
  input  logic               load,
  input  logic [WIDTH-1:0]   data,
  input  logic [2:0]         mode,
  input  logic [STEP-1:0]    shiftin,
  input  logic               start,
  input  logic [CNT_W-1:0]   count,
  output logic [WIDTH-1:0]   q,
  output logic [STEP-1:0]    shiftout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ASR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } shiftMode_t;

  localparam logic [WIDTH-1:0] SET_VALUE = WIDTH'(SVALUE);

  logic [WIDTH-1:0] r_q;
  logic [STEP-1:0]  r_shiftout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_remaining;
  logic [2:0]       r_modeLatched;

  logic [2:0]       w_opMode;
  logic [WIDTH-1:0] w_opResult;
  logic [STEP-1:0]  w_opOut;
  logic             w_opShift;

  // A burst keeps using the mode captured at start; otherwise the live mode input applies.
  assign w_opMode = r_busy ? r_modeLatched : mode;

  // Next register value and outgoing bits for one operation; reserved and hold modes leave everything alone.
  always_comb begin
    w_opResult = r_q;
    w_opOut    = r_shiftout;
    w_opShift  = 1'b0;
    case (w_opMode)
      MODE_SHL: begin
        w_opResult = {r_q[WIDTH-STEP-1:0], shiftin};
        w_opOut    = r_q[WIDTH-1 -: STEP];
        w_opShift  = 1'b1;
      end
      MODE_SHR: begin
        w_opResult = {shiftin, r_q[WIDTH-1:STEP]};
        w_opOut    = r_q[STEP-1:0];
        w_opShift  = 1'b1;
      end
      MODE_ASR: begin
        w_opResult = {{STEP{r_q[WIDTH-1]}}, r_q[WIDTH-1:STEP]};
        w_opOut    = r_q[STEP-1:0];
        w_opShift  = 1'b1;
      end
      MODE_ROL: begin
        w_opResult = {r_q[WIDTH-STEP-1:0], r_q[WIDTH-1 -: STEP]};
        w_opOut    = r_q[WIDTH-1 -: STEP];
        w_opShift  = 1'b1;
      end
      MODE_ROR: begin
        w_opResult = {r_q[STEP-1:0], r_q[WIDTH-1:STEP]};
        w_opOut    = r_q[STEP-1:0];
        w_opShift  = 1'b1;
      end
      default: begin
        w_opShift = 1'b0;
      end
    endcase
  end

  // Register, burst counter and handshake update; done is cleared every edge even when disabled so it stays a single-cycle pulse.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_q           <= '0;
      r_shiftout    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_remaining   <= '0;
      r_modeLatched <= MODE_HOLD;
    end else begin
      r_done <= 1'b0;
      if (enable) begin
        if (sclr) begin
          r_q         <= '0;
          r_shiftout  <= '0;
          r_busy      <= 1'b0;
          r_remaining <= '0;
        end else if (sset) begin
          r_q         <= SET_VALUE;
          r_busy      <= 1'b0;
          r_remaining <= '0;
        end else if (r_busy) begin
          if (w_opShift) begin
            r_q        <= w_opResult;
            r_shiftout <= w_opOut;
          end
          r_remaining <= r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end else if (load) begin
          r_q <= data;
        end else if (start) begin
          if (count != '0) begin
            r_modeLatched <= mode;
            r_remaining   <= count;
            r_busy        <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
        end else if (w_opShift) begin
          r_q        <= w_opResult;
          r_shiftout <= w_opOut;
        end
      end
    end
  end

  assign q        = r_q;
  assign shiftout = r_shiftout;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
